// File: rtl/nvme_srlat_pkg.sv
// Shared types and helpers for the sticky status latch bank and its interrupt FSM.
package nvme_srlat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ACKED = 2'd2
  } irq_state_e;

  // Ceiling log2 for elaboration-time sizing checks; returns 0 for values <= 1.
  function automatic int clog2_i(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nvme_prienc.sv
// Lowest-index priority encoder: reports the index of the least significant set request bit.
module nvme_prienc #(
  parameter int width = 128,
  parameter int idxw  = 7
) (
  input  logic [width-1:0] req_in,
  output logic [idxw-1:0]  idx_out,
  output logic             valid_out
);

  logic [width-1:0] lowest;
  logic [idxw-1:0]  term [width];

  // Two's-complement trick isolates the least significant set bit without a ripple chain.
  assign lowest    = req_in & ((~req_in) + width'(1));
  assign valid_out = |req_in;

  generate
    for (genvar gi = 0; gi < width; gi++) begin : g_term
      assign term[gi] = lowest[gi] ? idxw'(gi) : '0;
    end
  endgenerate

  always_comb begin
    idx_out = '0;
    for (int i = 0; i < width; i++) begin
      idx_out = idx_out | term[i];
    end
  end

endmodule

// File: rtl/nvme_srlat_irq.sv
// Sticky status/error latch bank with W1C clear, interrupt mask, first-event capture,
// saturating new-event counter and a request/acknowledge interrupt FSM.
module nvme_srlat_irq
  import nvme_srlat_pkg::*;
#(
  parameter int width = 128,
  parameter int cntw  = 16,
  parameter int idxw  = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] set_in,
  input  logic [width-1:0] clr_in,
  input  logic [width-1:0] mask_in,
  input  logic             first_clr,
  input  logic             cnt_clr,
  input  logic             irq_ack,
  output logic [width-1:0] hold_out,
  output logic             first_valid,
  output logic [idxw-1:0]  first_idx,
  output logic [cntw-1:0]  event_cnt,
  output logic             irq_out
);

  generate
    if (idxw < clog2_i(width)) begin : g_bad_idxw
      $error("nvme_srlat_irq: idxw too small to index all status bits");
    end
  endgenerate

  irq_state_e       state_q, state_d;
  logic [width-1:0] hold_q, hold_d;
  logic             first_valid_q, first_valid_d;
  logic [idxw-1:0]  first_idx_q, first_idx_d;
  logic [cntw-1:0]  event_cnt_q, event_cnt_d;
  logic             irq_q, irq_d;

  logic [width-1:0] newbits;
  logic             new_any;
  logic             new_masked;
  logic             pending;
  logic [idxw-1:0]  low_idx;

  assign newbits    = set_in & ~hold_q;
  assign new_masked = |(newbits & mask_in);
  assign pending    = |(hold_q & mask_in);

  nvme_prienc #(
    .width (width),
    .idxw  (idxw)
  ) u_prienc (
    .req_in    (newbits),
    .idx_out   (low_idx),
    .valid_out (new_any)
  );

  always_comb begin
    // Set dominates clear so an event arriving with a W1C strobe is never lost.
    hold_d        = set_in | (hold_q & ~clr_in);
    event_cnt_d   = event_cnt_q;
    first_valid_d = first_valid_q;
    first_idx_d   = first_idx_q;
    state_d       = state_q;

    if (cnt_clr) begin
      event_cnt_d = '0;
    end else if (new_any && (event_cnt_q != {cntw{1'b1}})) begin
      event_cnt_d = event_cnt_q + cntw'(1);
    end

    if (first_clr) begin
      first_valid_d = 1'b0;
      first_idx_d   = '0;
    end else if (!first_valid_q && new_any) begin
      first_valid_d = 1'b1;
      first_idx_d   = low_idx;
    end

    case (state_q)
      ST_IDLE: begin
        if (new_masked || pending) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (irq_ack) state_d = ST_ACKED;
      end
      ST_ACKED: begin
        // Only a fresh masked event re-raises; an old pending bit just keeps us parked here.
        if (new_masked) begin
          state_d = ST_REQ;
        end else if (!pending) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    irq_d = (state_q == ST_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      hold_q        <= '0;
      first_valid_q <= 1'b0;
      first_idx_q   <= '0;
      event_cnt_q   <= '0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      first_valid_q <= first_valid_d;
      first_idx_q   <= first_idx_d;
      event_cnt_q   <= event_cnt_d;
      irq_q         <= irq_d;
    end
  end

  assign hold_out    = hold_q;
  assign first_valid = first_valid_q;
  assign first_idx   = first_idx_q;
  assign event_cnt   = event_cnt_q;
  assign irq_out     = irq_q;

endmodule
